// File: rtl/frame_buffer_pkg.sv
// Shared types, constants and colour helper for the N-buffered frame store.
// Buffer roles, writer states, read latency and RGB888 expansion.
package frame_buffer_pkg;

    typedef enum logic [1:0] {
        WRITE,
        PENDING,
        DISPLAY,
        FREE
    } buf_role_e;

    typedef enum logic {
        WRITING,
        STALLED
    } writer_state_e;

    typedef logic [1:0] bank_idx_t;

    localparam int READ_LATENCY = 3;

    function automatic logic [23:0] expand_to_rgb888(
        input logic [23:0] pix,
        input int          width
    );
        if (width == 16)
            return {pix[15:11], 3'b0, pix[10:5], 2'b0, pix[4:0], 3'b0};
        return pix;
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One frame bank: simple dual-port RAM, one write port, one read port.
// Ports: i_clk, i_we/i_waddr/i_wdata (write), i_raddr -> o_rdata (2-cycle read).
module fb_bank #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 57600,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rdata;

    // RAM output latch plus output register: two cycles address to data
    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        r_q     <= r_mem[i_raddr];
        r_rdata <= r_q;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_buffer_nbuf.sv
// N-buffered (2/3) frame store: random-order low-res writes in, upscaled
// raster-order RGB888 out, buffer swap only at video frame boundaries.
// Ports: pixel_clk_in, rst_n_in (async, active-low), hcount_in, vcount_in,
//   video_last_pixel_in, ray_valid_in/ray_address_in/ray_pixel_in/
//   ray_last_pixel_in, ray_ready_out, frame_swap_out, rgb_out.
// Optional macro FRAME_BUFFER_STATS_EN adds frames_shown_out and
//   frames_dropped_out (16-bit wrapping counters).
module frame_buffer_nbuf
    import frame_buffer_pkg::*;
#(
    parameter int  PIXEL_WIDTH        = 16,
    parameter int  NUM_BUFFERS        = 2,
    parameter int  SCALE_SHIFT        = 2,
    parameter int  FULL_SCREEN_WIDTH  = 1280,
    parameter int  FULL_SCREEN_HEIGHT = 720,
    localparam int SCREEN_WIDTH       = FULL_SCREEN_WIDTH >> SCALE_SHIFT,
    localparam int SCREEN_HEIGHT      = FULL_SCREEN_HEIGHT >> SCALE_SHIFT,
    localparam int DEPTH              = SCREEN_WIDTH * SCREEN_HEIGHT,
    localparam int ADDR_WIDTH         = $clog2(DEPTH)
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   video_last_pixel_in,
    input  logic                   ray_valid_in,
    input  logic [ADDR_WIDTH-1:0]  ray_address_in,
    input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
    input  logic                   ray_last_pixel_in,
    output logic                   ray_ready_out,
    output logic                   frame_swap_out,
`ifdef FRAME_BUFFER_STATS_EN
    output logic [15:0]            frames_shown_out,
    output logic [15:0]            frames_dropped_out,
`endif
    output logic [23:0]            rgb_out
);

    generate
        if (!(PIXEL_WIDTH == 16 || PIXEL_WIDTH == 24)) begin : g_bad_pw
            $error("frame_buffer_nbuf: PIXEL_WIDTH must be 16 or 24");
        end
        if (!(NUM_BUFFERS == 2 || NUM_BUFFERS == 3)) begin : g_bad_nb
            $error("frame_buffer_nbuf: NUM_BUFFERS must be 2 or 3");
        end
    endgenerate

    writer_state_e r_wstate;
    writer_state_e w_wstate_nxt;
    bank_idx_t     r_write_idx;
    bank_idx_t     r_disp_idx;
    bank_idx_t     r_pend_idx;
    logic          r_pend_valid;
    logic          r_shown_valid;
    logic          r_ready;
    logic          r_swap;

    bank_idx_t     w_write_nxt;
    bank_idx_t     w_disp_nxt;
    bank_idx_t     w_pend_nxt;
    logic          w_pend_valid_nxt;
    logic          w_ready_nxt;
    bank_idx_t     w_free_idx;

    logic w_accept;
    logic w_in_mem;
    logic w_wr_ok;
    logic w_ray_last;
    logic w_swap;

    assign w_accept   = ray_valid_in && r_ready;
    assign w_in_mem   = 32'(ray_address_in) < DEPTH;
    assign w_wr_ok    = w_accept && w_in_mem;
    assign w_ray_last = w_accept && ray_last_pixel_in;
    // A frame finishing this very cycle counts as pending for the swap
    assign w_swap     = video_last_pixel_in && (r_pend_valid || w_ray_last);
    // Indices 0+1+2 = 3: with no pending bank the free one is the remainder
    assign w_free_idx = 2'(3) - r_write_idx - r_disp_idx;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wstate      <= WRITING;
            r_write_idx   <= 2'd1;
            r_disp_idx    <= 2'd0;
            r_pend_idx    <= 2'd0;
            r_pend_valid  <= 1'b0;
            r_shown_valid <= 1'b0;
            r_ready       <= 1'b1;
            r_swap        <= 1'b0;
        end else begin
            r_wstate      <= w_wstate_nxt;
            r_write_idx   <= w_write_nxt;
            r_disp_idx    <= w_disp_nxt;
            r_pend_idx    <= w_pend_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_shown_valid <= r_shown_valid | w_swap;
            r_ready       <= w_ready_nxt;
            r_swap        <= w_swap;
        end
    end

    always_comb begin
        w_wstate_nxt     = r_wstate;
        w_write_nxt      = r_write_idx;
        w_disp_nxt       = r_disp_idx;
        w_pend_nxt       = r_pend_idx;
        w_pend_valid_nxt = r_pend_valid;
        if (NUM_BUFFERS == 3) begin
            // Newest wins: a stale pending bank is recycled as the writer
            if (w_ray_last && w_swap) begin
                w_disp_nxt       = r_write_idx;
                w_write_nxt      = r_pend_valid ? r_pend_idx : w_free_idx;
                w_pend_valid_nxt = 1'b0;
            end else if (w_ray_last) begin
                w_pend_nxt       = r_write_idx;
                w_pend_valid_nxt = 1'b1;
                w_write_nxt      = r_pend_valid ? r_pend_idx : w_free_idx;
            end else if (w_swap) begin
                w_disp_nxt       = r_pend_idx;
                w_pend_valid_nxt = 1'b0;
            end
        end else begin
            unique case (r_wstate)
                WRITING: begin
                    if (w_ray_last && w_swap) begin
                        w_disp_nxt  = r_write_idx;
                        w_write_nxt = r_disp_idx;
                    end else if (w_ray_last) begin
                        w_pend_nxt       = r_write_idx;
                        w_pend_valid_nxt = 1'b1;
                        w_wstate_nxt     = STALLED;
                    end
                end
                STALLED: begin
                    if (w_swap) begin
                        w_disp_nxt       = r_pend_idx;
                        w_write_nxt      = r_disp_idx;
                        w_pend_valid_nxt = 1'b0;
                        w_wstate_nxt     = WRITING;
                    end
                end
                default: w_wstate_nxt = WRITING;
            endcase
        end
    end

    always_comb begin
        w_ready_nxt = (w_wstate_nxt == WRITING);
    end

    assign ray_ready_out  = r_ready;
    assign frame_swap_out = r_swap;

`ifdef FRAME_BUFFER_STATS_EN
    logic [15:0] r_shown_cnt;
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    assign w_drop = (NUM_BUFFERS == 3) && w_ray_last && r_pend_valid;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_shown_cnt <= 16'd0;
            r_drop_cnt  <= 16'd0;
        end else begin
            r_shown_cnt <= r_shown_cnt + 16'(w_swap);
            r_drop_cnt  <= r_drop_cnt + 16'(w_drop)
                         + 16'(ray_valid_in && !r_ready);
        end
    end

    assign frames_shown_out   = r_shown_cnt;
    assign frames_dropped_out = r_drop_cnt;
`endif

    // Write side
    logic [NUM_BUFFERS-1:0] w_we;
    logic [PIXEL_WIDTH-1:0] w_bank_rd [NUM_BUFFERS];

    // Read side: address register, bank select and visibility share one pipe
    logic [31:0]                        w_rd_addr_full;
    logic                               w_rd_in_range;
    logic [ADDR_WIDTH-1:0]              r_rd_addr;
    logic [READ_LATENCY-1:0][1:0]       r_sel_pipe;
    logic [READ_LATENCY-1:0]            r_vis_pipe;
    logic [PIXEL_WIDTH-1:0]             w_rd_pix;

    assign w_rd_addr_full = 32'(hcount_in >> SCALE_SHIFT)
                          + 32'(SCREEN_WIDTH) * 32'(vcount_in >> SCALE_SHIFT);
    assign w_rd_in_range  = (32'(hcount_in) < FULL_SCREEN_WIDTH)
                         && (32'(vcount_in) < FULL_SCREEN_HEIGHT);

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_addr  <= '0;
            r_sel_pipe <= '0;
            r_vis_pipe <= '0;
        end else begin
            r_rd_addr  <= w_rd_in_range ? ADDR_WIDTH'(w_rd_addr_full) : '0;
            r_sel_pipe <= {r_sel_pipe[READ_LATENCY-2:0], r_disp_idx};
            r_vis_pipe <= {r_vis_pipe[READ_LATENCY-2:0],
                           w_rd_in_range && r_shown_valid};
        end
    end

    for (genvar gi = 0; gi < NUM_BUFFERS; gi++) begin : g_bank
        assign w_we[gi] = w_wr_ok && (r_write_idx == 2'(gi));
        fb_bank #(
            .WIDTH      (PIXEL_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .i_clk   (pixel_clk_in),
            .i_we    (w_we[gi]),
            .i_waddr (ray_address_in),
            .i_wdata (ray_pixel_in),
            .i_raddr (r_rd_addr),
            .o_rdata (w_bank_rd[gi])
        );
    end

    always_comb begin
        w_rd_pix = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (r_sel_pipe[READ_LATENCY-1] == 2'(i))
                w_rd_pix = w_bank_rd[i];
        end
    end

    assign rgb_out = r_vis_pipe[READ_LATENCY-1]
                   ? expand_to_rgb888(24'(w_rd_pix), PIXEL_WIDTH)
                   : 24'h0;

endmodule

// File: tb/tb_frame_buffer_nbuf.sv
// Directed bench: a double- and a triple-buffered instance share stimulus;
// read expectations go through a scoreboard queue checked 3 cycles later.
module tb_frame_buffer_nbuf;

    localparam int PW  = 16;
    localparam int SS  = 2;
    localparam int FSW = 120;
    localparam int FSH = 64;
    localparam int AW  = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        vlast;
    logic        rvalid;
    logic [AW-1:0] raddr;
    logic [PW-1:0] rpix;
    logic        rlast;

    logic        ready2, swap2, ready3, swap3;
    logic [23:0] rgb2, rgb3;
`ifdef FRAME_BUFFER_STATS_EN
    logic [15:0] shown2, dropped2, shown3, dropped3;
`endif

    always #5 clk = ~clk;

    frame_buffer_nbuf #(
        .PIXEL_WIDTH(PW), .NUM_BUFFERS(2), .SCALE_SHIFT(SS),
        .FULL_SCREEN_WIDTH(FSW), .FULL_SCREEN_HEIGHT(FSH)
    ) u_dut2 (
        .pixel_clk_in        (clk),
        .rst_n_in            (rst_n),
        .hcount_in           (hcount),
        .vcount_in           (vcount),
        .video_last_pixel_in (vlast),
        .ray_valid_in        (rvalid),
        .ray_address_in      (raddr),
        .ray_pixel_in        (rpix),
        .ray_last_pixel_in   (rlast),
        .ray_ready_out       (ready2),
        .frame_swap_out      (swap2),
`ifdef FRAME_BUFFER_STATS_EN
        .frames_shown_out    (shown2),
        .frames_dropped_out  (dropped2),
`endif
        .rgb_out             (rgb2)
    );

    frame_buffer_nbuf #(
        .PIXEL_WIDTH(PW), .NUM_BUFFERS(3), .SCALE_SHIFT(SS),
        .FULL_SCREEN_WIDTH(FSW), .FULL_SCREEN_HEIGHT(FSH)
    ) u_dut3 (
        .pixel_clk_in        (clk),
        .rst_n_in            (rst_n),
        .hcount_in           (hcount),
        .vcount_in           (vcount),
        .video_last_pixel_in (vlast),
        .ray_valid_in        (rvalid),
        .ray_address_in      (raddr),
        .ray_pixel_in        (rpix),
        .ray_last_pixel_in   (rlast),
        .ray_ready_out       (ready3),
        .frame_swap_out      (swap3),
`ifdef FRAME_BUFFER_STATS_EN
        .frames_shown_out    (shown3),
        .frames_dropped_out  (dropped3),
`endif
        .rgb_out             (rgb3)
    );

    typedef struct {
        int          due;
        int          h;
        int          v;
        logic [23:0] e2;
        logic [23:0] e3;
    } rd_exp_t;

    rd_exp_t sb[$];
    int n_asrt = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        rd_exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check($sformatf("rgb2(%0d,%0d)", e.h, e.v), 32'(rgb2), 32'(e.e2));
            check($sformatf("rgb3(%0d,%0d)", e.h, e.v), 32'(rgb3), 32'(e.e3));
        end
    endtask

    task automatic rd(input int h, input int v,
                      input logic [23:0] e2, input logic [23:0] e3);
        hcount = 11'(h);
        vcount = 10'(v);
        sb.push_back('{cyc + 3, h, v, e2, e3});
        tick();
    endtask

    task automatic wr(input int a, input logic [15:0] p, input bit last);
        rvalid = 1'b1;
        raddr  = AW'(a);
        rpix   = p;
        rlast  = last;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b1; hcount = '0; vcount = '0; vlast = 1'b0;
        rvalid = 1'b0; raddr = '0; rpix = '0; rlast = 1'b0;

        // Reset state, asynchronous
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready2", 32'(ready2), 32'd1);
        check("rst_ready3", 32'(ready3), 32'd1);
        check("rst_swap2", 32'(swap2), 32'd0);
        check("rst_swap3", 32'(swap3), 32'd0);
        check("rst_rgb2", 32'(rgb2), 32'd0);
        check("rst_rgb3", 32'(rgb3), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
`ifdef FRAME_BUFFER_STATS_EN
        check("st_shown0", 32'(shown2), 32'd0);
        check("st_drop0", 32'(dropped3), 32'd0);
`endif

        // Nothing shown before the first swap
        rd(0, 0, 24'h0, 24'h0);
        rd(4, 4, 24'h0, 24'h0);
        drain();

        // Frame A: solid red
        for (int a = 0; a < 480; a++) wr(a, 16'hF800, a == 479);
        check("stall_ready2", 32'(ready2), 32'd0);
        check("nostall_ready3", 32'(ready3), 32'd1);

        // Write while double-buffer stalled
        wr(31, 16'h001F, 1'b0);
        check("stalled_ready2", 32'(ready2), 32'd0);
        check("free_ready3", 32'(ready3), 32'd1);
`ifdef FRAME_BUFFER_STATS_EN
        check("st_drop2_a", 32'(dropped2), 32'd1);
`endif

        // Swap in frame A
        vlast = 1'b1;
        tick();
        vlast = 1'b0;
        check("swapA_2", 32'(swap2), 32'd1);
        check("swapA_3", 32'(swap3), 32'd1);
        check("swapA_ready2", 32'(ready2), 32'd1);
        tick();
        check("swapA_end2", 32'(swap2), 32'd0);
        check("swapA_end3", 32'(swap3), 32'd0);
        rd(0, 0, 24'hF80000, 24'hF80000);
        rd(119, 63, 24'hF80000, 24'hF80000);
        rd(120, 0, 24'h0, 24'h0);
        rd(0, 64, 24'h0, 24'h0);
        rd(4, 4, 24'hF80000, 24'hF80000);
        drain();

        // Frame B: solid green, last flag on a discarded address
        for (int a = 0; a < 480; a++) wr(a, 16'h07E0, 1'b0);
        wr(480, 16'hF800, 1'b1);
        check("B_ready2", 32'(ready2), 32'd0);
        check("B_ready3", 32'(ready3), 32'd1);

        // Frame C: only the triple buffer takes it, newest wins
        wr(0, 16'h001F, 1'b0);
        wr(30, 16'hF800, 1'b0);
        wr(32, 16'hF800, 1'b0);
        wr(1, 16'hF800, 1'b0);
        wr(61, 16'hF800, 1'b0);
        wr(31, 16'h07E0, 1'b1);
        check("C_ready2", 32'(ready2), 32'd0);
        check("C_ready3", 32'(ready3), 32'd1);
`ifdef FRAME_BUFFER_STATS_EN
        check("st_drop2_c", 32'(dropped2), 32'd7);
        check("st_drop3_c", 32'(dropped3), 32'd1);
`endif

        // Pixel issued on the swap cycle still reads the old bank
        vlast = 1'b1;
        rd(0, 0, 24'hF80000, 24'hF80000);
        vlast = 1'b0;
        check("swap2_2", 32'(swap2), 32'd1);
        check("swap2_3", 32'(swap3), 32'd1);
        check("swap2_ready2", 32'(ready2), 32'd1);
        rd(0, 0, 24'h00FC00, 24'h0000F8);
        rd(4, 4, 24'h00FC00, 24'h00FC00);
        rd(7, 7, 24'h00FC00, 24'h00FC00);
        rd(7, 4, 24'h00FC00, 24'h00FC00);
        rd(4, 7, 24'h00FC00, 24'h00FC00);
        rd(3, 4, 24'h00FC00, 24'hF80000);
        rd(8, 4, 24'h00FC00, 24'hF80000);
        rd(4, 3, 24'h00FC00, 24'hF80000);
        rd(4, 8, 24'h00FC00, 24'hF80000);
        drain();

        // Frame boundary with nothing pending: no swap
        vlast = 1'b1;
        tick();
        vlast = 1'b0;
        check("noswap2", 32'(swap2), 32'd0);
        check("noswap3", 32'(swap3), 32'd0);
        rd(0, 0, 24'h00FC00, 24'h0000F8);
        drain();

        // Ray and video frame ends in the same cycle
        rvalid = 1'b1; raddr = AW'(0); rpix = 16'hFFFF; rlast = 1'b1;
        vlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0; vlast = 1'b0;
        check("sim_swap2", 32'(swap2), 32'd1);
        check("sim_swap3", 32'(swap3), 32'd1);
        check("sim_ready2", 32'(ready2), 32'd1);
        check("sim_ready3", 32'(ready3), 32'd1);
        tick();
        check("sim_ready2b", 32'(ready2), 32'd1);
        rd(0, 0, 24'hF8FCF8, 24'hF8FCF8);
        rd(4, 4, 24'hF80000, 24'h00FC00);
        rd(0, 0, 24'hF8FCF8, 24'hF8FCF8);
        drain();
`ifdef FRAME_BUFFER_STATS_EN
        check("st_shown2", 32'(shown2), 32'd3);
        check("st_shown3", 32'(shown3), 32'd3);
`endif

        // Reset mid-write with the double buffer stalled
        wr(7, 16'h0000, 1'b1);
        check("pre_rst_ready2", 32'(ready2), 32'd0);
        check("pre_rst_rgb2", 32'(rgb2), 32'hF8FCF8);
        check("pre_rst_rgb3", 32'(rgb3), 32'hF8FCF8);
        rvalid = 1'b1; raddr = AW'(5); rpix = 16'hF800;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready2", 32'(ready2), 32'd1);
        check("mid_rst_swap2", 32'(swap2), 32'd0);
        check("mid_rst_rgb2", 32'(rgb2), 32'd0);
        check("mid_rst_rgb3", 32'(rgb3), 32'd0);
`ifdef FRAME_BUFFER_STATS_EN
        check("st_rst_drop2", 32'(dropped2), 32'd0);
        check("st_rst_shown3", 32'(shown3), 32'd0);
`endif
        sb.delete();
        rvalid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        wr(0, 16'hF800, 1'b0);
        rd(0, 0, 24'h0, 24'h0);
        rd(4, 4, 24'h0, 24'h0);
        vlast = 1'b1;
        tick();
        vlast = 1'b0;
        check("post_rst_noswap2", 32'(swap2), 32'd0);
        rd(0, 0, 24'h0, 24'h0);
        drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
